// File: rtl/prog_loader.sv
// Byte-serial boot loader: parses SYNC/count/payload/checksum frames, writes big-endian
// 32-bit words into instruction memory and releases the CPU with a start pulse on success.
module prog_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          BASE_ADDR = 0,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_halt,
  output logic              cpu_start,
  output logic              busy,
  output logic              err,
  output logic [2:0]        dbg_state
);

  // Stream handshake: a byte moves when in_valid & in_ready are both high at a clk1 edge;
  // in_ready depends only on the current state, never on in_valid.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_HI = 3'd1,
    S_CNT_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [31:0]       MAX_WORDS = (32'd1 << ADDR_W) - 32'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  state_t              state, state_n;
  logic [7:0]          cnt_hi, cnt_hi_n;
  logic [15:0]         words_left, words_left_n;
  logic [1:0]          byte_idx, byte_idx_n;
  logic [23:0]         shift_q, shift_n;
  logic [7:0]          csum, csum_n;
  logic [ADDR_W-1:0]   cur_addr, cur_addr_n;
  logic                mem_we_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [31:0]         mem_wdata_n;
  logic                halt_n, busy_n, err_n;
  logic [15:0]         n_words;
  logic                xfer;

  always_ff @(posedge clk1) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt_hi     <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      shift_q    <= '0;
      csum       <= '0;
      cur_addr   <= BASE;
      mem_we     <= 1'b0;
      mem_addr   <= BASE;
      mem_wdata  <= '0;
      cpu_halt   <= 1'b1;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      cnt_hi     <= cnt_hi_n;
      words_left <= words_left_n;
      byte_idx   <= byte_idx_n;
      shift_q    <= shift_n;
      csum       <= csum_n;
      cur_addr   <= cur_addr_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      cpu_halt   <= halt_n;
      busy       <= busy_n;
      err        <= err_n;
    end
  end

  assign in_ready  = (state != S_DONE) && (state != S_ERR);
  assign cpu_start = (state == S_DONE);
  assign xfer      = in_valid & in_ready;
  assign dbg_state = state;

  always_comb begin
    state_n      = state;
    cnt_hi_n     = cnt_hi;
    words_left_n = words_left;
    byte_idx_n   = byte_idx;
    shift_n      = shift_q;
    csum_n       = csum;
    cur_addr_n   = cur_addr;
    mem_we_n     = 1'b0;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    halt_n       = cpu_halt;
    busy_n       = busy;
    err_n        = err;
    n_words      = {cnt_hi, in_data};

    case (state)
      S_IDLE: begin
        if (xfer && in_data == SYNC) begin
          state_n    = S_CNT_HI;
          halt_n     = 1'b1;
          busy_n     = 1'b1;
          err_n      = 1'b0;
          csum_n     = '0;
          byte_idx_n = '0;
          cur_addr_n = BASE;
        end
      end
      S_CNT_HI: begin
        if (xfer) begin
          cnt_hi_n = in_data;
          state_n  = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (xfer) begin
          // A count that would run past the top of memory is rejected before any write.
          if ({16'd0, n_words} > MAX_WORDS) begin
            state_n = S_ERR;
            busy_n  = 1'b0;
            err_n   = 1'b1;
          end else if (n_words == 16'd0) begin
            state_n = S_CSUM;
          end else begin
            state_n      = S_DATA;
            words_left_n = n_words;
            byte_idx_n   = '0;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          csum_n     = csum ^ in_data;
          shift_n    = {shift_q[15:0], in_data};
          byte_idx_n = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            mem_we_n     = 1'b1;
            mem_addr_n   = cur_addr;
            mem_wdata_n  = {shift_q, in_data};
            cur_addr_n   = cur_addr + 1'b1;
            words_left_n = words_left - 16'd1;
            if (words_left == 16'd1) state_n = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          busy_n = 1'b0;
          if (in_data == csum) begin
            state_n = S_DONE;
            halt_n  = 1'b0;
          end else begin
            state_n = S_ERR;
            err_n   = 1'b1;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: byte driver, write scoreboard, start-pulse counter, summary.
module tb_prog_loader;
  localparam int AW = 10;

  logic          clk1 = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_halt;
  logic          cpu_start;
  logic          busy;
  logic          err;
  logic [2:0]    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;
  logic [AW+31:0] exp_q[$];
  logic [31:0]    frame_w[0:7];

  prog_loader #(.ADDR_W(AW), .BASE_ADDR(0), .SYNC(8'hA5)) dut (
    .clk1(clk1), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_halt(cpu_halt),
    .cpu_start(cpu_start), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk1 = ~clk1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    @(posedge clk1);
    @(negedge clk1);
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 1);
    check_eq({tag, "_mem_we"}, mem_we, 0);
    check_eq({tag, "_mem_addr"}, mem_addr, 0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
    check_eq({tag, "_cpu_halt"}, cpu_halt, 1);
    check_eq({tag, "_cpu_start"}, cpu_start, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_state"}, dbg_state, 0);
  endtask

  // scoreboard: every write must match the head of the expected queue
  always @(negedge clk1) begin
    if (cpu_start) start_cnt++;
    if (mem_we) begin
      if (exp_q.size() == 0) check_eq("unexpected_write", 1, 0);
      else check_eq("mem_write", 64'({mem_addr, mem_wdata}), 64'(exp_q.pop_front()));
    end
  end

  // driver: called at a negedge, returns at the negedge after the byte is taken
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int tries;
    if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk1);
    in_data = b;
    in_valid = 1'b1;
    tries = 0;
    while (!in_ready && tries < 20) begin
      @(negedge clk1);
      tries++;
    end
    if (!in_ready) check_eq("ready_timeout", 0, 1);
    @(posedge clk1);
    @(negedge clk1);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit bad_csum, input int max_gap);
    logic [7:0] c;
    logic [31:0] w;
    c = 8'h00;
    send_byte(8'hA5, max_gap);
    send_byte(8'(n >> 8), max_gap);
    send_byte(8'(n), max_gap);
    for (int i = 0; i < n; i++) begin
      w = frame_w[i];
      exp_q.push_back({AW'(i), w});
      for (int k = 3; k >= 0; k--) begin
        c = c ^ w[k*8 +: 8];
        send_byte(w[k*8 +: 8], max_gap);
      end
    end
    send_byte(bad_csum ? (c ^ 8'h01) : c, max_gap);
  endtask

  task automatic check_outcome(input string tag, input int starts_before, input bit ok);
    repeat (3) @(negedge clk1);
    check_eq({tag, "_starts"}, 64'(start_cnt - starts_before), ok ? 1 : 0);
    check_eq({tag, "_err"}, err, !ok);
    check_eq({tag, "_halt"}, cpu_halt, !ok);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_ready"}, in_ready, 1);
    check_eq({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  initial begin
    int s0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    @(negedge clk1);
    do_reset();
    check_reset_values("reset");

    // clean two-word frame; checksum of the payload is 8'h01
    frame_w[0] = 32'h14010005;
    frame_w[1] = 32'h14020007;
    s0 = start_cnt;
    send_frame(2, 1'b0, 0);
    check_eq("done_state", dbg_state, 5);
    check_eq("done_ready", in_ready, 0);
    check_eq("done_start", cpu_start, 1);
    check_outcome("clean2", s0, 1'b1);
    check_eq("hold_addr", mem_addr, 1);
    check_eq("hold_wdata", mem_wdata, 32'h14020007);

    // same frame, checksum byte 8'h00: writes happen, then error
    s0 = start_cnt;
    send_frame(2, 1'b1, 0);
    check_eq("err_state", dbg_state, 6);
    check_eq("err_ready", in_ready, 0);
    check_outcome("badcsum", s0, 1'b0);

    // a following good frame clears err and starts the CPU
    s0 = start_cnt;
    send_frame(2, 1'b0, 0);
    check_outcome("recover", s0, 1'b1);

    // leading junk then an empty frame
    s0 = start_cnt;
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h12, 0);
    check_eq("junk_idle", dbg_state, 0);
    send_frame(0, 1'b0, 0);
    check_outcome("empty", s0, 1'b1);

    // count 0x0401 exceeds 1024 words
    s0 = start_cnt;
    send_byte(8'hA5, 0);
    check_eq("sync_busy", busy, 1);
    check_eq("sync_halt", cpu_halt, 1);
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    check_eq("ovf_state", dbg_state, 6);
    check_eq("ovf_err", err, 1);
    check_eq("ovf_busy", busy, 0);
    check_outcome("overflow", s0, 1'b0);

    // three words with ~50% valid duty; SYNC value appears as data
    frame_w[0] = 32'hDEADBEEF;
    frame_w[1] = 32'hA5A5A5A5;
    frame_w[2] = 32'h00000001;
    s0 = start_cnt;
    send_frame(3, 1'b0, 2);
    check_outcome("gaps", s0, 1'b1);

    // reset after two of three words
    s0 = start_cnt;
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({AW'(i), frame_w[i]});
      for (int k = 3; k >= 0; k--) send_byte(frame_w[i][k*8 +: 8], 0);
    end
    @(negedge clk1);
    check_eq("midframe_busy", busy, 1);
    do_reset();
    check_reset_values("midreset");
    check_eq("midreset_pending", exp_q.size(), 0);

    frame_w[0] = 32'h14010005;
    frame_w[1] = 32'h14020007;
    send_frame(2, 1'b0, 0);
    check_outcome("after_reset", s0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
